key_mode_ctrl: RTL and testbench

- Parametrised debounced push-button front end and mode selector. It generalises the single-key, undebounced mode counter in the top level.
- Runs on i2c_clk and generates its own sample tick.
- Synchronises and debounces N_KEYS active-low buttons, and emits clean level and press-pulse outputs.
- Drives a wrap-around mode register with increment, optional decrement, and hold-to-auto-repeat. The mode register feeds display/processing mode selects (e.g. the HDMI SLO input).

---
 rtl/key_mode_ctrl.sv | 116 +++++++++++
 tb/tb_key_mode_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounced push-button front end driving a wrap-around mode selector
module key_mode_ctrl #(
    parameter int N_KEYS       = 2,
    parameter int TICK_DIV     = 8000,
    parameter int DEB_CNT      = 4,
    parameter int NUM_MODES    = 3,
    parameter int MODE_W       = 2,
    parameter int MODE_RESET   = 0,
    parameter int INC_KEY      = 0,
    parameter int DEC_EN       = 1,
    parameter int DEC_KEY      = 1,
    parameter int REPEAT_TICKS = 62
) (
    input  logic              i2c_clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] key_press,
    output logic              tick,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam int DK = (DEC_EN != 0) ? DEC_KEY : INC_KEY;

    if (N_KEYS < 1 || N_KEYS > 8 || TICK_DIV < 2 || DEB_CNT < 1 || DEB_CNT > 15 ||
        NUM_MODES < 2 || NUM_MODES > 2**MODE_W || MODE_RESET >= NUM_MODES ||
        INC_KEY >= N_KEYS || (DEC_EN != 0 && (DEC_KEY >= N_KEYS || DEC_KEY == INC_KEY)))
    begin : g_bad_params
        $error("key_mode_ctrl: illegal parameter combination");
    end

    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_KEYS-1:0] key_db_q, key_db_d, key_press_q, key_press_d, pressed_s;
    logic [3:0]        deb_cnt_q [N_KEYS];
    logic [3:0]        deb_cnt_d [N_KEYS];
    logic [HW-1:0]     hold_q [2];
    logic [HW-1:0]     hold_d [2];
    logic [1:0]        rep_q, rep_d, hk_db, hk_press;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              mode_chg_q, mode_chg_d, up, down;

    always_comb begin
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        sync1_d    = key_n;
        sync2_d    = sync1_q;
        pressed_s  = ~sync2_q;
        key_db_d   = key_db_q;
        key_press_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (tick) begin
                if (pressed_s[i] == key_db_q[i]) deb_cnt_d[i] = '0;
                else if (deb_cnt_q[i] + 4'd1 == 4'(DEB_CNT)) begin
                    deb_cnt_d[i]   = '0;
                    key_db_d[i]    = ~key_db_q[i];
                    key_press_d[i] = ~key_db_q[i];
                end else deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
        end
        // slot 0 tracks the increment key, slot 1 the decrement key
        hk_db    = {key_db_q[DK], key_db_q[INC_KEY]};
        hk_press = {key_press_q[DK], key_press_q[INC_KEY]};
        rep_d    = '0;
        for (int k = 0; k < 2; k++) begin
            hold_d[k] = hold_q[k];
            if (REPEAT_TICKS == 0 || !hk_db[k] || hk_press[k]) hold_d[k] = '0;
            else if (tick) begin
                if (hold_q[k] + 1'b1 == HW'(REPEAT_TICKS)) begin
                    hold_d[k] = '0;
                    rep_d[k]  = 1'b1;
                end else hold_d[k] = hold_q[k] + 1'b1;
            end
        end
        up         = key_press_q[INC_KEY] | rep_q[0];
        down       = (DEC_EN != 0) & (key_press_q[DK] | rep_q[1]);
        mode_d     = mode_q;
        if (up && !down) mode_d = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + 1'b1;
        else if (down && !up) mode_d = (mode_q == '0) ? MODE_W'(NUM_MODES - 1) : mode_q - 1'b1;
        mode_chg_d = up ^ down;
    end

    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q  <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            key_db_q    <= '0;
            key_press_q <= '0;
            for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= '0;
            for (int k = 0; k < 2; k++) hold_q[k] <= '0;
            rep_q       <= '0;
            mode_q      <= MODE_W'(MODE_RESET);
            mode_chg_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_db_q    <= key_db_d;
            key_press_q <= key_press_d;
            for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            for (int k = 0; k < 2; k++) hold_q[k] <= hold_d[k];
            rep_q       <= rep_d;
            mode_q      <= mode_d;
            mode_chg_q  <= mode_chg_d;
        end
    end

    assign key_db    = key_db_q;
    assign key_press = key_press_q;
    assign mode      = mode_q;
    assign mode_chg  = mode_chg_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl: directed stimulus with a window/modulo reference model checked every cycle
module tb_key_mode_ctrl;
    logic       i2c_clk, reset_n;
    logic [1:0] key_n, key_db, key_press;
    logic       tick, mode_chg;
    logic [1:0] mode;

    int checks = 0, errors = 0;
    int chg_cnt = 0, tick_cnt = 0;
    int press_cnt [2] = '{0, 0};

    key_mode_ctrl #(
        .N_KEYS(2), .TICK_DIV(4), .DEB_CNT(3), .NUM_MODES(3), .MODE_W(2),
        .MODE_RESET(0), .INC_KEY(0), .DEC_EN(1), .DEC_KEY(1), .REPEAT_TICKS(5)
    ) dut (
        .i2c_clk(i2c_clk), .reset_n(reset_n), .key_n(key_n), .key_db(key_db),
        .key_press(key_press), .tick(tick), .mode(mode), .mode_chg(mode_chg)
    );

    initial i2c_clk = 1'b0;
    always #5 i2c_clk = ~i2c_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tick from cycle count, debounce as "last DEB_CNT tick samples all disagree",
    // repeat as "ticks held since press is a nonzero multiple of REPEAT_TICKS", mode modulo 3.
    int         m_cyc, m_mode;
    int         m_held [2];
    logic [2:0] m_hist [2];
    logic [1:0] m_s1, m_s2, m_db, m_press, m_rep;
    logic       m_chg;

    task automatic model_reset();
        m_cyc = 0; m_mode = 0; m_chg = 1'b0;
        m_s1 = '1; m_s2 = '1; m_db = '0; m_press = '0; m_rep = '0;
        for (int k = 0; k < 2; k++) begin
            m_held[k] = 0;
            m_hist[k] = '0;
        end
    endtask

    task automatic model_step();
        logic       t, up, dn;
        logic [1:0] p, n_db, n_press, n_rep;
        t = (m_cyc % 4 == 3);
        p = ~m_s2;
        n_db = m_db; n_press = '0; n_rep = '0;
        for (int k = 0; k < 2; k++) begin
            if (t) begin
                m_hist[k] = {m_hist[k][1:0], p[k]};
                if (m_hist[k] == {3{~m_db[k]}}) begin
                    n_db[k] = ~m_db[k];
                    n_press[k] = ~m_db[k];
                end
            end
            if (!m_db[k] || m_press[k]) m_held[k] = 0;
            else if (t) begin
                m_held[k]++;
                if (m_held[k] % 5 == 0) n_rep[k] = 1'b1;
            end
        end
        up = m_press[0] | m_rep[0];
        dn = m_press[1] | m_rep[1];
        m_mode = (m_mode + int'(up) - int'(dn) + 3) % 3;
        m_chg = (up != dn);
        m_db = n_db; m_press = n_press; m_rep = n_rep;
        m_s2 = m_s1; m_s1 = key_n;
        m_cyc++;
    endtask

    always @(negedge i2c_clk) begin
        if (!reset_n) model_reset();
        chk("tick", int'(tick), int'(m_cyc % 4 == 3));
        chk("key_db", int'(key_db), int'(m_db));
        chk("key_press", int'(key_press), int'(m_press));
        chk("mode", int'(mode), m_mode);
        chk("mode_chg", int'(mode_chg), int'(m_chg));
        if (mode_chg) chg_cnt++;
        if (tick) tick_cnt++;
        for (int k = 0; k < 2; k++) if (key_press[k]) press_cnt[k]++;
        if (reset_n) model_step();
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge i2c_clk);
        #2;
    endtask

    task automatic push(input logic [1:0] k, input int n, input int gap);
        key_n = ~k;
        cyc(n);
        key_n = '1;
        cyc(gap);
    endtask

    int b, b0, b1;
    int seq [7] = '{1, 2, 0, 2, 1, 2, 0};
    logic [1:0] seq_key [7] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};

    initial begin
        reset_n = 1'b0;
        key_n   = '1;
        cyc(3);
        reset_n = 1'b1;
        b = tick_cnt;
        cyc(200);
        chk("idle_tick_count", tick_cnt - b, 50);
        chk("idle_mode", int'(mode), 0);
        chk("idle_key_db", int'(key_db), 0);
        chk("idle_chg_count", chg_cnt, 0);
        chk("idle_press_count", press_cnt[0] + press_cnt[1], 0);
        push(2'b01, 8, 40);
        chk("bounce_key_db", int'(key_db), 0);
        chk("bounce_mode", int'(mode), 0);
        chk("bounce_press_count", press_cnt[0], 0);
        for (int s = 0; s < 7; s++) begin
            b = chg_cnt;
            push(seq_key[s], 16, 40);
            chk("step_mode", int'(mode), seq[s]);
            chk("step_chg_count", chg_cnt - b, 1);
        end
        b = chg_cnt;
        push(2'b01, 72, 40);
        chk("repeat_mode", int'(mode), 1);
        chk("repeat_chg_count", chg_cnt - b, 4);
        b = chg_cnt; b0 = press_cnt[0]; b1 = press_cnt[1];
        push(2'b11, 16, 40);
        chk("both_mode", int'(mode), 1);
        chk("both_chg_count", chg_cnt - b, 0);
        chk("both_press0", press_cnt[0] - b0, 1);
        chk("both_press1", press_cnt[1] - b1, 1);
        key_n = 2'b00;
        cyc(30);
        chk("hold_key_db", int'(key_db), 3);
        reset_n = 1'b0;
        key_n = 2'b10;
        #3;
        chk("async_rst_mode", int'(mode), 0);
        chk("async_rst_key_db", int'(key_db), 0);
        cyc(5);
        reset_n = 1'b1;
        b = chg_cnt;
        cyc(16);
        key_n = '1;
        cyc(40);
        chk("post_rst_mode", int'(mode), 1);
        chk("post_rst_chg_count", chg_cnt - b, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
